// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared types and constants for the MIPS25 ALU resource controllers.
//   arb_state_t : controller phase (IDLE -> SETTLE -> CAPTURE -> IDLE)
//   SEL_A/SEL_B : mux select encoding, also used as requester identity
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-request round-robin picker (purely combinational).
// Ports:
//   req_a, req_b : request levels
//   last_served  : requester served most recently (SEL_A / SEL_B)
//   grant_b      : 1 when B wins, 0 when A wins (only meaningful with any_req)
//   any_req      : at least one request is pending
// -----------------------------------------------------------------------------
module rr_arb2
    import alu_ctrl_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_served,
    output logic grant_b,
    output logic any_req
);

    // B wins when it is the only requester, or on a tie when A was served last.
    assign grant_b = req_b & (~req_a | (last_served == SEL_A));
    assign any_req = req_a | req_b;

endmodule

// File: rtl/alu_mux_arbiter.sv
// -----------------------------------------------------------------------------
// alu_mux_arbiter
// Sequencing controller for the 16-bit adiabatic operand mux. Picks A or B
// round-robin, drives the mux select, holds it for HOLD_CYCLES so the
// adiabatic stages settle, captures the mux output and returns it to the
// granted requester with a one-cycle ack.
// Ports:
//   clkpos, rst         : clock, asynchronous active-high reset
//   req_a, req_b        : operand requests
//   data_a, data_b      : operands (wired straight to the mux, unused here)
//   mux_out             : mux output, captured at the end of SETTLE
//   mux_sel             : mux select (0 = a, 1 = b)
//   ack_a, ack_b        : one-cycle completion pulses
//   result, result_valid: captured operand and its one-cycle valid
//   busy                : high in SETTLE and CAPTURE
//   owner               : requester currently or last served
// -----------------------------------------------------------------------------
module alu_mux_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int HOLD_CYCLES = 4    // must be >= 1
)(
    input  logic             clkpos,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] mux_out,
    output logic             mux_sel,
    output logic             ack_a,
    output logic             ack_b,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             owner
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mux_sel;
    logic             r_owner;
    logic             r_last_served;
    logic             r_ack_a;
    logic             r_ack_b;
    logic             r_result_valid;
    logic [WIDTH-1:0] r_result;

    logic             w_grant_b;
    logic             w_any_req;
    logic             w_grant;
    logic             w_capture;

    // Operands go straight to the mux; the controller only sees mux_out.
    logic             w_unused_data;
    assign w_unused_data = ^{data_a, data_b};

    rr_arb2 u_rr_arb2 (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_served (r_last_served),
        .grant_b     (w_grant_b),
        .any_req     (w_any_req)
    );

    // State register
    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Select, counter and capture registers
    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            r_mux_sel      <= SEL_A;
            r_owner        <= SEL_A;
            r_last_served  <= SEL_B;   // A wins the first tie after reset
            r_cnt          <= '0;
            r_ack_a        <= 1'b0;
            r_ack_b        <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
        end else begin
            r_ack_a        <= 1'b0;
            r_ack_b        <= 1'b0;
            r_result_valid <= 1'b0;

            // mux_sel only moves on a grant so an idle mux never toggles.
            if (w_grant) begin
                r_mux_sel <= w_grant_b;
                r_owner   <= w_grant_b;
                r_cnt     <= CNT_W'(HOLD_CYCLES - 1);
            end

            if (r_state == SETTLE && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_capture) begin
                r_result       <= mux_out;
                r_result_valid <= 1'b1;
                r_ack_a        <= (r_owner == SEL_A);
                r_ack_b        <= (r_owner == SEL_B);
            end

            if (r_state == CAPTURE) begin
                r_last_served <= r_owner;
            end
        end
    end

    assign mux_sel      = r_mux_sel;
    assign owner        = r_owner;
    assign ack_a        = r_ack_a;
    assign ack_b        = r_ack_b;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_alu_mux_arbiter.sv
module tb_alu_mux_arbiter;

    localparam int W = 16;
    localparam int H = 4;

    logic         clkpos = 1'b0;
    logic         rst;
    logic         req_a, req_b;
    logic [W-1:0] data_a, data_b, mux_out, result;
    logic         mux_sel, ack_a, ack_b, result_valid, busy, owner;

    alu_mux_arbiter #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
        .clkpos       (clkpos),
        .rst          (rst),
        .req_a        (req_a),
        .req_b        (req_b),
        .data_a       (data_a),
        .data_b       (data_b),
        .mux_out      (mux_out),
        .mux_sel      (mux_sel),
        .ack_a        (ack_a),
        .ack_b        (ack_b),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 clkpos = ~clkpos;

    // Behavioural model of mux2to1_16b
    assign mux_out = mux_sel ? data_b : data_a;

    int checks = 0;
    int errors = 0;

    // Transaction-timeline reference model: an operation granted at edge g
    // captures at edge g+H and releases the controller at edge g+H+1.
    bit           m_active;
    int           m_n, m_g;
    logic         m_sel, m_owner, m_last, m_ack_a, m_ack_b, m_rv, m_busy, m_gnt;
    logic [W-1:0] m_result;

    typedef struct {
        logic         ra, rb;
        logic [W-1:0] da, db;
        logic         own;
        logic [W-1:0] res;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_n = 0; m_g = 0;
        m_sel = 0; m_owner = 0; m_last = 1;
        m_ack_a = 0; m_ack_b = 0; m_rv = 0; m_busy = 0;
        m_result = '0;
    endtask

    task automatic model_edge();
        m_n++;
        m_ack_a = 0; m_ack_b = 0; m_rv = 0;
        if (!m_active) begin
            if (req_a || req_b) begin
                m_gnt    = (req_a && req_b) ? ~m_last : req_b;
                m_active = 1;
                m_g      = m_n;
                m_sel    = m_gnt;
                m_owner  = m_gnt;
            end
        end else if (m_n == m_g + H) begin
            m_result = m_sel ? data_b : data_a;
            m_rv     = 1;
            if (m_owner) m_ack_b = 1; else m_ack_a = 1;
        end else if (m_n == m_g + H + 1) begin
            m_active = 0;
            m_last   = m_owner;
        end
        m_busy = m_active;
    endtask

    task automatic check_all();
        chk("mux_sel", 32'(mux_sel), 32'(m_sel));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("ack_a", 32'(ack_a), 32'(m_ack_a));
        chk("ack_b", 32'(ack_b), 32'(m_ack_b));
        chk("result_valid", 32'(result_valid), 32'(m_rv));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("result", 32'(result), 32'(m_result));
    endtask

    task automatic step();
        @(posedge clkpos);
        if (rst) model_reset(); else model_edge();
        #1;
        check_all();
    endtask

    // Runs edges until an ack appears (bounded), checks latency counted from
    // the first edge, owner and result, then drops the acked request.
    task automatic run_op(input string tag, input logic exp_own, input logic [W-1:0] exp_res);
        bit seen;
        int lat;
        seen = 0;
        lat  = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step();
            if (ack_a || ack_b) begin
                seen = 1;
                lat  = k;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no ack within 20 cycles, expected owner %0d", tag, exp_own);
        end else begin
            chk({tag, "_latency"}, 32'(lat), 32'(H + 1));
            chk({tag, "_owner"}, 32'(owner), 32'(exp_own));
            chk({tag, "_ack_side"}, 32'(ack_b), 32'(exp_own));
            chk({tag, "_result"}, 32'(result), 32'(exp_res));
            if (exp_own) req_b = 1'b0; else req_a = 1'b0;
        end
        step();
    endtask

    initial begin
        logic         sel0;
        bit           seen;
        int           lat;
        logic [W-1:0] cap;

        tbl[0] = '{1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0, 16'h1234};
        tbl[1] = '{1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b1, 16'hBEEF};
        tbl[2] = '{1'b1, 1'b1, 16'h0A0A, 16'h0B0B, 1'b0, 16'h0A0A};
        tbl[3] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, 16'h2222};
        tbl[4] = '{1'b0, 1'b1, 16'h3333, 16'hC3C3, 1'b1, 16'hC3C3};
        tbl[5] = '{1'b1, 1'b1, 16'h4444, 16'h5555, 1'b0, 16'h4444};
        tbl[6] = '{1'b1, 1'b0, 16'h6666, 16'h7777, 1'b0, 16'h6666};
        tbl[7] = '{1'b1, 1'b1, 16'h8888, 16'h9999, 1'b1, 16'h9999};

        // Reset state
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
        model_reset();
        #1;
        check_all();
        step();
        step();
        rst = 1'b0;
        step();

        // Table-driven operations: ties, single requests, alternation
        for (int i = 0; i < 8; i++) begin
            req_a  = tbl[i].ra;
            req_b  = tbl[i].rb;
            data_a = tbl[i].da;
            data_b = tbl[i].db;
            run_op($sformatf("vec%0d", i), tbl[i].own, tbl[i].res);
        end
        req_a = 1'b0; req_b = 1'b0;
        step();

        // Withdrawn request: B drops req right after grant
        data_b = 16'hABCD; req_b = 1'b1;
        step();
        req_b = 1'b0;
        seen = 0; lat = 0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            step();
            if (ack_b) begin seen = 1; lat = k; end
        end
        chk("withdraw_ack_seen", 32'(seen), 32'd1);
        chk("withdraw_latency", 32'(lat), 32'(H));
        chk("withdraw_result", 32'(result), 32'hABCD);
        step(); step(); step();
        chk("withdraw_no_regrant", 32'(busy), 32'd0);

        // Reset two cycles after grant
        data_a = 16'h5A5A; req_a = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        rst = 1'b0;
        run_op("post_reset", 1'b0, 16'h5A5A);

        // Select stability with data toggling every cycle during SETTLE
        req_b = 1'b1; data_b = 16'h0F0F;
        step();
        sel0 = mux_sel;
        chk("stab_sel_b", 32'(sel0), 32'd1);
        cap = '0;
        for (int k = 0; k < H; k++) begin
            data_a = 16'($urandom);
            data_b = 16'($urandom);
            cap    = data_b;
            step();
            chk("stab_sel_held", 32'(mux_sel), 32'(sel0));
        end
        chk("stab_capture", 32'(result), 32'(cap));
        chk("stab_ack_b", 32'(ack_b), 32'd1);
        req_b = 1'b0;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            req_a  = ($urandom_range(0, 3) != 0);
            req_b  = ($urandom_range(0, 2) != 0);
            data_a = 16'($urandom);
            data_b = 16'($urandom);
            step();
            chk("ack_exclusive", 32'(ack_a & ack_b), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
